// File: rtl/sin_seq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : sin_ctrl_pkg
// Brief    : Shared types, default widths and the saturation helper for the
//            sine LUT sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sin_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_ACC_W  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_CNT_W  = 16;
    localparam int GAIN_FRAC  = 7;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
        logic signed [31:0] w_hi;
        logic signed [31:0] w_lo;
        w_hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        w_lo = -(32'sd1 <<< (w - 1));
        if (v > w_hi)
            return w_hi;
        else if (v < w_lo)
            return w_lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sin_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : sin_seq_ctrl_if
// Brief    : Valid/ready sample stream from the sequencer toward the DAC path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sin_seq_ctrl_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (output smp_data, output smp_valid, input smp_ready);
    modport slave  (input smp_data, input smp_valid, output smp_ready);
endinterface

`default_nettype wire

// File: rtl/sin_seq_ctrl_rate_div.sv
//------------------------------------------------------------------------------
// Module   : sin_rate_div
// Brief    : Sample tick generator, one tick every div+1 enabled cycles
//            (div of 0 behaves as 1). Loading presets so the first cycle ticks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sin_rate_div #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_div_eff;

    assign w_div_eff = (div_in == '0) ? CNT_W'(1) : div_in;
    assign tick      = en && (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= CNT_W'(1);
            r_cnt <= '0;
        end else if (load) begin
            r_div <= w_div_eff;
            r_cnt <= w_div_eff;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sin_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : sin_seq_ctrl
// Brief    : Sine LUT sequencer: phase accumulator, rate divider, burst/continuous
//            control and a valid/ready sample output. Optional macro
//            SIN_CTRL_GAIN_EN adds a Q1.7 gain input with saturation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sin_seq_ctrl
    import sin_ctrl_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [CNT_W-1:0]  rate_div,
    input  logic [CNT_W-1:0]  burst_len,
`ifdef SIN_CTRL_GAIN_EN
    input  logic [7:0]        gain,
`endif
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    sin_seq_ctrl_if.master    smp,
    output logic              period_sync,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_done;
    logic               w_tick;
    logic               w_carry;
    logic               w_last_wrap;
    logic [ACC_W:0]     w_sum;
    logic [DATA_W-1:0]  w_cap_val;

    logic [ACC_W-1:0]   r_fw;
    logic [CNT_W-1:0]   r_bl;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_periods;
    logic [ADDR_W-1:0]  r_lut_addr;
    logic               r_rd_pend;
    logic               r_cap_pend;
    logic [DATA_W-1:0]  r_smp_data;
    logic               r_smp_valid;
    logic               r_psync;
    logic               r_overrun;

    sin_rate_div #(.CNT_W(CNT_W)) u_rate_div (
        .clk    (clkin),
        .rst    (rst),
        .load   (w_load),
        .en     (r_state == RUN),
        .div_in (rate_div),
        .tick   (w_tick)
    );

    assign w_sum       = {1'b0, r_acc} + {1'b0, r_fw};
    assign w_carry     = w_sum[ACC_W];
    assign w_last_wrap = w_tick && w_carry && (r_bl != '0) && ((r_periods + CNT_W'(1)) == r_bl);

`ifdef SIN_CTRL_GAIN_EN
    logic signed [31:0] w_lut_ext;
    logic signed [31:0] w_gain_ext;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_scaled;

    assign w_lut_ext  = {{(32-DATA_W){lut_data[DATA_W-1]}}, lut_data};
    assign w_gain_ext = {24'd0, gain};
    assign w_prod     = w_lut_ext * w_gain_ext;
    assign w_scaled   = w_prod >>> GAIN_FRAC;
    assign w_cap_val  = DATA_W'(saturate(w_scaled, DATA_W));
`else
    assign w_cap_val  = lut_data;
`endif

    always_ff @(posedge clkin) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (stop || w_last_wrap)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                // Both read stages must be empty so the last LUT sample lands.
                if (!r_rd_pend && !r_cap_pend && (!r_smp_valid || smp.smp_ready)) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_fw        <= '0;
            r_bl        <= '0;
            r_acc       <= '0;
            r_periods   <= '0;
            r_lut_addr  <= '0;
            r_rd_pend   <= 1'b0;
            r_cap_pend  <= 1'b0;
            r_smp_data  <= '0;
            r_smp_valid <= 1'b0;
            r_psync     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_psync    <= 1'b0;
            r_rd_pend  <= w_tick;
            r_cap_pend <= r_rd_pend;
            if (w_load) begin
                r_fw      <= freq_word;
                r_bl      <= burst_len;
                r_acc     <= '0;
                r_periods <= '0;
                r_overrun <= 1'b0;
            end else if (w_tick) begin
                r_lut_addr <= r_acc[ACC_W-1 -: ADDR_W];
                r_acc      <= w_sum[ACC_W-1:0];
                if (w_carry) begin
                    r_psync   <= 1'b1;
                    r_periods <= r_periods + CNT_W'(1);
                end
            end
            // LUT data is valid two edges after the tick that set the address.
            if (r_cap_pend) begin
                if (!r_smp_valid || smp.smp_ready) begin
                    r_smp_data  <= w_cap_val;
                    r_smp_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (smp.smp_ready) begin
                r_smp_valid <= 1'b0;
            end
        end
    end

    assign lut_addr      = r_lut_addr;
    assign smp.smp_data  = r_smp_data;
    assign smp.smp_valid = r_smp_valid;
    assign period_sync   = r_psync;
    assign busy          = (r_state != IDLE);
    assign done          = w_done && !rst;
    assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sin_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_sin_seq_ctrl
// Brief    : Self-checking bench for sin_seq_ctrl with a schedule-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sin_seq_ctrl;

    logic        clkin = 1'b0;
    logic        rst, start, stop;
    logic [15:0] freq_word, rate_div, burst_len;
    logic [3:0]  lut_addr;
    logic [11:0] lut_data = 12'h000;
    logic        period_sync, busy, done, overrun;

    sin_seq_ctrl_if #(.DATA_W(12)) smp();

    sin_seq_ctrl dut (
        .clkin       (clkin),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .freq_word   (freq_word),
        .rate_div    (rate_div),
        .burst_len   (burst_len),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .smp         (smp),
        .period_sync (period_sync),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clkin = ~clkin;

    // Registered LUT: one cycle from address to data.
    always @(posedge clkin) lut_data <= 12'h100 + {8'd0, lut_addr};

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tick schedule and a queue of outstanding LUT reads.
    int m_mode = 0;   // 0 idle, 1 run, 2 drain
    int m_acc = 0, m_fw = 0, m_rd = 1, m_bl = 0, m_periods = 0, m_next_tick = 0;
    int m_addr = 0, m_data = 0;
    bit m_valid = 0, m_psync = 0, m_overrun = 0;
    int pq_edge[$];
    int pq_val[$];
    int edge_n = 0;

    always @(posedge clkin) begin
        bit drain_ok;
        edge_n++;
        if (rst) begin
            m_mode = 0; m_acc = 0; m_addr = 0; m_data = 0; m_periods = 0;
            m_valid = 0; m_psync = 0; m_overrun = 0;
            pq_edge.delete(); pq_val.delete();
        end else begin
            drain_ok = (pq_edge.size() == 0) && (!m_valid || smp.smp_ready);
            m_psync = 0;
            if (pq_edge.size() > 0 && pq_edge[0] == edge_n) begin
                if (!m_valid || smp.smp_ready) begin
                    m_data  = pq_val[0];
                    m_valid = 1;
                end else begin
                    m_overrun = 1;
                end
                void'(pq_edge.pop_front());
                void'(pq_val.pop_front());
            end else if (smp.smp_ready) begin
                m_valid = 0;
            end
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_fw = int'(freq_word);
                    m_rd = (rate_div == 16'd0) ? 1 : int'(rate_div);
                    m_bl = int'(burst_len); m_acc = 0; m_periods = 0; m_overrun = 0;
                    m_next_tick = edge_n + 1;
                end
                1: begin
                    if (edge_n == m_next_tick) begin
                        m_addr = m_acc / 4096;
                        pq_edge.push_back(edge_n + 2);
                        pq_val.push_back(256 + m_addr);
                        m_acc += m_fw;
                        m_next_tick += m_rd + 1;
                        if (m_acc >= 65536) begin
                            m_acc -= 65536;
                            m_psync = 1;
                            m_periods = (m_periods + 1) % 65536;
                            if (m_bl != 0 && m_periods == m_bl) m_mode = 2;
                        end
                    end
                    if (stop) m_mode = 2;
                end
                default: if (drain_ok) m_mode = 0;
            endcase
        end
    end

    always @(negedge clkin) begin
        if (chk_en) begin
            chk("lut_addr", {28'd0, lut_addr}, m_addr);
            chk("smp_valid", {31'd0, smp.smp_valid}, {31'd0, m_valid});
            chk("smp_data", {20'd0, smp.smp_data}, m_data);
            chk("period_sync", {31'd0, period_sync}, {31'd0, m_psync});
            chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
            chk("done", {31'd0, done},
                {31'd0, !rst && m_mode == 2 && pq_edge.size() == 0 && (!m_valid || smp.smp_ready)});
            chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
        end
    end

    int acc_q[$];
    int n_psync = 0, n_done = 0;
    always @(posedge clkin) if (!rst && smp.smp_valid && smp.smp_ready) acc_q.push_back(int'(smp.smp_data));
    always @(negedge clkin) begin
        if (period_sync) n_psync++;
        if (done) n_done++;
    end

    task automatic step();
        @(posedge clkin);
        #1;
        if (rnd_ready) smp.smp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_seq(input logic [15:0] fw, input logic [15:0] rd, input logic [15:0] bl);
        freq_word = fw; rate_div = rd; burst_len = bl; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        freq_word = '0; rate_div = '0; burst_len = '0; smp.smp_ready = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, smp.smp_valid}, 32'd0);
        chk("reset_addr", {28'd0, lut_addr}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step();

        // Single period, one sample per two cycles.
        acc_q.delete(); n_psync = 0; n_done = 0;
        start_seq(16'h1000, 16'd1, 16'd1);
        wait_idle(200);
        chk("burst1_count", acc_q.size(), 32'd16);
        foreach (acc_q[i]) chk("burst1_sample", acc_q[i], 32'h100 + i);
        chk("burst1_psync", n_psync, 32'd1);
        chk("burst1_done", n_done, 32'd1);
        step();

        // Two periods at double step.
        acc_q.delete(); n_psync = 0; n_done = 0;
        start_seq(16'h2000, 16'd1, 16'd2);
        wait_idle(200);
        chk("burst2_count", acc_q.size(), 32'd16);
        foreach (acc_q[i]) chk("burst2_sample", acc_q[i], 32'h100 + ((2 * i) % 16));
        chk("burst2_psync", n_psync, 32'd2);
        chk("burst2_done", n_done, 32'd1);
        step();

        // Backpressure causes drops.
        smp.smp_ready = 1'b0;
        start_seq(16'h1000, 16'd1, 16'd0);
        repeat (8) step();
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_hold", {20'd0, smp.smp_data}, 32'h100);
        smp.smp_ready = 1'b1;
        repeat (10) step();
        stop = 1'b1; step(); stop = 1'b0;
        wait_idle(100);
        step();

        // Stop mid-run while the consumer stalls.
        acc_q.delete(); n_done = 0;
        start_seq(16'h1000, 16'd1, 16'd0);
        chk("start_clears_overrun", {31'd0, overrun}, 32'd0);
        n = 0;
        while (acc_q.size() < 5 && n < 100) begin step(); n++; end
        chk("stop_wait_timeout", {31'd0, acc_q.size() >= 5}, 32'd1);
        stop = 1'b1; smp.smp_ready = 1'b0;
        step();
        stop = 1'b0;
        step(); step();
        chk("drain_hold", {31'd0, busy}, 32'd1);
        smp.smp_ready = 1'b1;
        wait_idle(50);
        chk("stop_done", n_done, 32'd1);
        step();

        // Reset during RUN.
        start_seq(16'h1000, 16'd1, 16'd0);
        repeat (6) step();
        d0 = n_done;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, smp.smp_valid}, 32'd0);
        chk("rst_addr", {28'd0, lut_addr}, 32'd0);
        step();
        chk("rst_no_done", n_done, d0);

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            logic [15:0] bl;
            bl = 16'($urandom_range(0, 3));
            rnd_ready = 1'b1;
            stop = (r == 0);
            start_seq(16'($urandom_range(16'h0800, 16'h4000)), 16'($urandom_range(0, 3)), bl);
            stop = 1'b0;
            if (bl == 16'd0) begin
                repeat ($urandom_range(10, 60)) step();
                stop = 1'b1; step(); stop = 1'b0;
            end
            wait_idle(3000);
            rnd_ready = 1'b0;
            smp.smp_ready = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
